// File: rtl/capture_ctrl_pkg.sv
// Shared types for the capture sequence controller: FSM state encoding and
// the width rule for the issued/delivered readback counters.
package capture_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        RUN,
        DRAIN,
        READ,
        DONE
    } cap_state_e;

    // One extra bit so the counters can hold max_ram_address == 2**aw.
    function automatic int cnt_width(input int aw);
        return aw + 1;
    endfunction

endpackage

// File: rtl/capture_sequence_ctrl_if.sv
// RAM port plus valid/ready readback stream of the capture sequence controller.
interface capture_sequence_ctrl_if #(
    parameter int address_width = 14,
    parameter int data_width    = 33
);
    logic                     ram_wren;
    logic [address_width-1:0] ram_addr;
    logic [data_width-1:0]    ram_q;
    logic [data_width-1:0]    rd_data;
    logic                     rd_valid;
    logic                     rd_ready;

    modport master (
        output ram_wren, ram_addr, rd_data, rd_valid,
        input  ram_q, rd_ready
    );

    modport slave (
        input  ram_wren, ram_addr, rd_data, rd_valid,
        output ram_q, rd_ready
    );
endinterface

// File: rtl/readback_skid_fifo.sv
// Two-entry FIFO holding RAM read data; entry 0 is always the head, so the
// head data/valid come straight from flops.
module readback_skid_fifo #(
    parameter int data_width = 33
) (
    input  logic                  variable_clk,
    input  logic                  reset_n,
    input  logic                  clr,
    input  logic                  push,
    input  logic [data_width-1:0] push_data,
    input  logic                  pop,
    output logic [data_width-1:0] head_data,
    output logic                  head_valid,
    output logic [1:0]            count
);
    logic [data_width-1:0] d0_q, d0_d, d1_q, d1_d;
    logic                  v0_q, v0_d, v1_q, v1_d;

    always_comb begin
        d0_d = d0_q;
        d1_d = d1_q;
        v0_d = v0_q;
        v1_d = v1_q;
        // Pop first so a push into a full FIFO lands in the slot just freed.
        if (pop && v0_q) begin
            d0_d = d1_q;
            v0_d = v1_q;
            d1_d = '0;
            v1_d = 1'b0;
        end
        if (push) begin
            if (!v0_d) begin
                d0_d = push_data;
                v0_d = 1'b1;
            end else begin
                d1_d = push_data;
                v1_d = 1'b1;
            end
        end
        if (clr) begin
            d0_d = '0;
            d1_d = '0;
            v0_d = 1'b0;
            v1_d = 1'b0;
        end
    end

    always_ff @(posedge variable_clk) begin
        if (!reset_n) begin
            d0_q <= '0;
            d1_q <= '0;
            v0_q <= 1'b0;
            v1_q <= 1'b0;
        end else begin
            d0_q <= d0_d;
            d1_q <= d1_d;
            v0_q <= v0_d;
            v1_q <= v1_d;
        end
    end

    assign head_data  = d0_q;
    assign head_valid = v0_q;
    assign count      = {1'b0, v0_q} + {1'b0, v1_q};
endmodule

// File: rtl/capture_sequence_ctrl.sv
// Capture run sequencer: arm the LFSR, gate the clock while filling the RAM,
// drain, then stream the captured words out over valid/ready.
module capture_sequence_ctrl
    import capture_ctrl_pkg::*;
#(
    parameter int address_width   = 14,
    parameter int max_ram_address = 4096,
    parameter int data_width      = 33,
    parameter int arm_cycles      = 4,
    parameter int drain_cycles    = 2
) (
    input  logic variable_clk,
    input  logic reset_n,
    input  logic start_req,
    input  logic abort,
    output logic start_signal,
    output logic enable,
    output logic busy,
    output logic done,
    capture_sequence_ctrl_if.master bus
);
    localparam int CNT_W  = cnt_width(address_width);
    localparam int PH_MAX = (arm_cycles > drain_cycles) ? arm_cycles : drain_cycles;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam logic [CNT_W-1:0]         MAX_C      = CNT_W'(max_ram_address);
    localparam logic [address_width-1:0] LAST_ADDR  = address_width'(max_ram_address - 1);
    localparam logic [PH_W-1:0]          ARM_LAST   = PH_W'(arm_cycles - 1);
    localparam logic [PH_W-1:0]          DRAIN_LAST = PH_W'((drain_cycles > 0) ? drain_cycles - 1 : 0);

    cap_state_e               state_q, state_d;
    logic [PH_W-1:0]          phase_q, phase_d;
    logic [address_width-1:0] ram_addr_q, ram_addr_d;
    logic [CNT_W-1:0]         issued_q, issued_d, deliv_q, deliv_d;
    logic                     inflight_q, inflight_d;
    logic                     start_cur_q, start_cur_d, start_prev_q, start_prev_d;
    logic                     start_signal_q, start_signal_d, enable_q, enable_d;
    logic                     ram_wren_q, ram_wren_d, busy_q, busy_d, done_q, done_d;

    logic                  start_edge, issue, pop, fifo_clr, fifo_valid;
    logic [data_width-1:0] fifo_data;
    logic [1:0]            fifo_count;
    logic [2:0]            occ;

    assign start_edge = start_cur_q & ~start_prev_q;
    assign pop        = fifo_valid & bus.rd_ready;
    // Slots already claimed after this cycle's pop: FIFO entries plus the word on ram_q.
    assign occ        = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        ram_addr_d   = ram_addr_q;
        issued_d     = issued_q;
        deliv_d      = deliv_q;
        inflight_d   = 1'b0;
        issue        = 1'b0;
        fifo_clr     = 1'b0;
        start_cur_d  = start_req;
        start_prev_d = start_cur_q;
        case (state_q)
            IDLE, DONE: if (start_edge) begin
                state_d = ARM;
                phase_d = '0;
            end
            ARM: if (phase_q == ARM_LAST) begin
                state_d = RUN;
                phase_d = '0;
            end else begin
                phase_d = phase_q + PH_W'(1);
            end
            RUN: if (ram_addr_q == LAST_ADDR) begin
                state_d    = DRAIN;
                ram_addr_d = '0;
            end else begin
                ram_addr_d = ram_addr_q + address_width'(1);
            end
            DRAIN: if (phase_q == DRAIN_LAST) begin
                state_d = READ;
                phase_d = '0;
            end else begin
                phase_d = phase_q + PH_W'(1);
            end
            READ: begin
                issue      = (issued_q < MAX_C) && (occ < 3'd2);
                inflight_d = issue;
                if (issue) begin
                    ram_addr_d = ram_addr_q + address_width'(1);
                    issued_d   = issued_q + CNT_W'(1);
                end
                if (pop) deliv_d = deliv_q + CNT_W'(1);
                if (pop && (deliv_q == MAX_C - CNT_W'(1))) begin
                    state_d    = DONE;
                    ram_addr_d = '0;
                    issued_d   = '0;
                    deliv_d    = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d    = IDLE;
            phase_d    = '0;
            ram_addr_d = '0;
            issued_d   = '0;
            deliv_d    = '0;
            inflight_d = 1'b0;
            fifo_clr   = 1'b1;
        end
        start_signal_d = (state_d == ARM);
        enable_d       = (state_d == RUN);
        ram_wren_d     = (state_d == RUN);
        busy_d         = (state_d != IDLE) && (state_d != DONE);
        done_d         = (state_d == DONE);
    end

    always_ff @(posedge variable_clk) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            phase_q        <= '0;
            ram_addr_q     <= '0;
            issued_q       <= '0;
            deliv_q        <= '0;
            inflight_q     <= 1'b0;
            // Track the live input so a level held through reset is not an edge.
            start_cur_q    <= start_req;
            start_prev_q   <= start_req;
            start_signal_q <= 1'b0;
            enable_q       <= 1'b0;
            ram_wren_q     <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            ram_addr_q     <= ram_addr_d;
            issued_q       <= issued_d;
            deliv_q        <= deliv_d;
            inflight_q     <= inflight_d;
            start_cur_q    <= start_cur_d;
            start_prev_q   <= start_prev_d;
            start_signal_q <= start_signal_d;
            enable_q       <= enable_d;
            ram_wren_q     <= ram_wren_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    readback_skid_fifo #(.data_width(data_width)) u_fifo (
        .variable_clk (variable_clk),
        .reset_n      (reset_n),
        .clr          (fifo_clr),
        .push         (inflight_q),
        .push_data    (bus.ram_q),
        .pop          (pop),
        .head_data    (fifo_data),
        .head_valid   (fifo_valid),
        .count        (fifo_count)
    );

    assign start_signal = start_signal_q;
    assign enable       = enable_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign bus.ram_wren = ram_wren_q;
    assign bus.ram_addr = ram_addr_q;
    assign bus.rd_data  = fifo_data;
    assign bus.rd_valid = fifo_valid;
endmodule

// File: tb/tb_capture_sequence_ctrl.sv
// Bench: DUT0 captures 6 words, DUT1 captures 8 (full 3-bit address space).
// A run is checked against its expected timeline and a readback scoreboard.
module tb_capture_sequence_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n[2], sr[2], ab[2], rdy[2];
    logic ss[2], en[2], bsy[2], dn[2];
    logic wren_a[2], vld_a[2];
    logic [2:0]  addr_a[2];
    logic [32:0] dat_a[2];
    int checks = 0;
    int errors = 0;

    capture_sequence_ctrl_if #(.address_width(3), .data_width(33)) bus0();
    capture_sequence_ctrl_if #(.address_width(3), .data_width(33)) bus1();

    capture_sequence_ctrl #(.address_width(3), .max_ram_address(6), .data_width(33),
                            .arm_cycles(2), .drain_cycles(1)) u_dut0 (
        .variable_clk(clk), .reset_n(rst_n[0]), .start_req(sr[0]), .abort(ab[0]),
        .start_signal(ss[0]), .enable(en[0]), .busy(bsy[0]), .done(dn[0]), .bus(bus0.master));

    capture_sequence_ctrl #(.address_width(3), .max_ram_address(8), .data_width(33),
                            .arm_cycles(2), .drain_cycles(1)) u_dut1 (
        .variable_clk(clk), .reset_n(rst_n[1]), .start_req(sr[1]), .abort(ab[1]),
        .start_signal(ss[1]), .enable(en[1]), .busy(bsy[1]), .done(dn[1]), .bus(bus1.master));

    // RAM model: registered read, data = addr + 0x10.
    always @(posedge clk) begin
        bus0.ram_q <= 33'(bus0.ram_addr) + 33'h10;
        bus1.ram_q <= 33'(bus1.ram_addr) + 33'h10;
    end
    assign bus0.rd_ready = rdy[0];
    assign bus1.rd_ready = rdy[1];
    assign wren_a[0] = bus0.ram_wren;  assign wren_a[1] = bus1.ram_wren;
    assign addr_a[0] = bus0.ram_addr;  assign addr_a[1] = bus1.ram_addr;
    assign vld_a[0]  = bus0.rd_valid;  assign vld_a[1]  = bus1.rd_valid;
    assign dat_a[0]  = bus0.rd_data;   assign dat_a[1]  = bus1.rd_data;

    typedef struct {
        logic rst, sr, ab;
        logic ss, en, wren;
        logic [2:0] addr;
        logic busy, done;
    } vec_t;

    function automatic vec_t mk(int r, int s, int a, int xs, int xe, int xw, int xa, int xb, int xd);
        vec_t v;
        v.rst = 1'(r); v.sr = 1'(s); v.ab = 1'(a);
        v.ss = 1'(xs); v.en = 1'(xe); v.wren = 1'(xw); v.addr = 3'(xa);
        v.busy = 1'(xb); v.done = 1'(xd);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // mode 0: ready always 1; 1: ready 1,0,0 repeating; 2: random ready.
    // glitch: extra start edges during ARM and READ that must be dropped.
    task automatic do_run(input int d, input int mode, input bit glitch);
        int maxa, got, first, last;
        bit stall, fin;
        logic [32:0] held;
        maxa = (d == 0) ? 6 : 8;
        sr[d] = 1'b1;
        tick();
        chk("pre_arm_ss", ss[d], 0);
        sr[d] = 1'b0;
        tick();
        chk("arm1_ss", ss[d], 1); chk("arm1_done", dn[d], 0); chk("arm1_busy", bsy[d], 1);
        sr[d] = glitch;
        tick();
        chk("arm2_ss", ss[d], 1); chk("arm2_en", en[d], 0);
        sr[d] = 1'b0;
        for (int k = 0; k < maxa; k++) begin
            tick();
            chk("run_en", en[d], 1); chk("run_wren", wren_a[d], 1);
            chk("run_addr", addr_a[d], k); chk("run_ss", ss[d], 0);
        end
        tick();
        chk("drain_en", en[d], 0); chk("drain_wren", wren_a[d], 0);
        chk("drain_addr", addr_a[d], 0); chk("drain_busy", bsy[d], 1);
        got = 0; first = -1; last = -1; stall = 0; fin = 0; held = '0;
        for (int c = 0; c < 200 && !fin; c++) begin
            tick();
            if (got == maxa) begin
                chk("done_after_last", dn[d], 1); chk("done_busy", bsy[d], 0);
                chk("done_valid", vld_a[d], 0);
                fin = 1;
            end else begin
                if (stall) begin
                    chk("stall_valid", vld_a[d], 1); chk("stall_data", dat_a[d], held);
                end
                if (glitch) sr[d] = (c == 3);
                case (mode)
                    0: rdy[d] = 1'b1;
                    1: rdy[d] = (c % 3 == 0);
                    default: rdy[d] = 1'($urandom_range(0, 1));
                endcase
                stall = 0;
                if (vld_a[d]) begin
                    if (first < 0) first = c;
                    chk("rd_data", dat_a[d], 33'h10 + 33'(got));
                    if (rdy[d]) begin
                        got++;
                        last = c;
                    end else begin
                        stall = 1;
                        held = dat_a[d];
                    end
                end
            end
        end
        if (!fin) begin
            errors++;
            $display("FAIL done_timeout: got %0d words expected %0d", got, maxa);
        end
        if (mode == 0) begin
            chk("first_valid_cycle", first, 2);
            chk("stream_last_cycle", last, first + maxa - 1);
        end
        sr[d] = 1'b0;
        rdy[d] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("done_hold", dn[d], 1); chk("done_no_restart", bsy[d], 0);
        end
    endtask

    vec_t tbl[20];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tbl[0]  = mk(0,0,0, 0,0,0,0,0,0);
        tbl[1]  = mk(0,0,0, 0,0,0,0,0,0);
        tbl[2]  = mk(1,0,0, 0,0,0,0,0,0);
        tbl[3]  = mk(1,1,0, 0,0,0,0,0,0);
        tbl[4]  = mk(1,1,0, 1,0,0,0,1,0);
        tbl[5]  = mk(1,1,0, 1,0,0,0,1,0);
        tbl[6]  = mk(1,0,0, 0,1,1,0,1,0);
        tbl[7]  = mk(1,0,0, 0,1,1,1,1,0);
        tbl[8]  = mk(1,0,0, 0,1,1,2,1,0);
        tbl[9]  = mk(1,0,0, 0,1,1,3,1,0);
        tbl[10] = mk(1,0,1, 0,0,0,0,0,0);
        tbl[11] = mk(1,0,0, 0,0,0,0,0,0);
        tbl[12] = mk(1,1,0, 0,0,0,0,0,0);
        tbl[13] = mk(1,1,0, 1,0,0,0,1,0);
        tbl[14] = mk(1,1,1, 0,0,0,0,0,0);
        tbl[15] = mk(1,0,0, 0,0,0,0,0,0);
        tbl[16] = mk(1,1,0, 0,0,0,0,0,0);
        tbl[17] = mk(1,1,1, 0,0,0,0,0,0);
        tbl[18] = mk(1,1,0, 0,0,0,0,0,0);
        tbl[19] = mk(1,1,0, 0,0,0,0,0,0);
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; sr[d] = 1'b0; ab[d] = 1'b0; rdy[d] = 1'b0;
        end
        // Reset, abort mid-RUN, abort in ARM, abort beating a start edge.
        for (int i = 0; i < 20; i++) begin
            rst_n[0] = tbl[i].rst; sr[0] = tbl[i].sr; ab[0] = tbl[i].ab;
            rst_n[1] = tbl[i].rst;
            tick();
            chk($sformatf("vec%0d_ss", i), ss[0], tbl[i].ss);
            chk($sformatf("vec%0d_en", i), en[0], tbl[i].en);
            chk($sformatf("vec%0d_wren", i), wren_a[0], tbl[i].wren);
            chk($sformatf("vec%0d_addr", i), addr_a[0], tbl[i].addr);
            chk($sformatf("vec%0d_busy", i), bsy[0], tbl[i].busy);
            chk($sformatf("vec%0d_done", i), dn[0], tbl[i].done);
        end
        chk("dut1_reset_busy", bsy[1], 0);
        chk("dut1_reset_valid", vld_a[1], 0);
        sr[0] = 1'b0;
        tick(); tick();

        do_run(0, 0, 1'b0);            // nominal after abort
        do_run(0, 0, 1'b1);            // dropped starts in ARM/READ
        do_run(0, 0, 1'b0);            // restart from DONE
        do_run(0, 1, 1'b0);            // backpressure
        for (int r = 0; r < 4; r++) do_run(0, 2, 1'b0);

        // Reset while a word is waiting in READ.
        rdy[0] = 1'b0;
        sr[0] = 1'b1; tick(); sr[0] = 1'b0;
        n = 0;
        while (!vld_a[0] && n < 60) begin
            tick();
            n++;
        end
        chk("pre_reset_valid", vld_a[0], 1);
        rst_n[0] = 1'b0; sr[0] = 1'b1;
        tick();
        chk("rst_ss", ss[0], 0); chk("rst_en", en[0], 0); chk("rst_wren", wren_a[0], 0);
        chk("rst_addr", addr_a[0], 0); chk("rst_valid", vld_a[0], 0); chk("rst_data", dat_a[0], 0);
        chk("rst_busy", bsy[0], 0); chk("rst_done", dn[0], 0);
        tick();
        rst_n[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("held_start_no_run_busy", bsy[0], 0);
            chk("held_start_no_run_ss", ss[0], 0);
        end
        sr[0] = 1'b0;
        tick();
        do_run(0, 0, 1'b0);

        // Full address space: 8 writes, no wrap, 8 words back.
        do_run(1, 0, 1'b0);
        do_run(1, 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
